// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the burst SRAM controller.
// Holds the FSM state encoding and the BURST_LEN / BE_W derivations.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Beats per read burst for a given BURST_BITS
    function automatic int burst_len(input int bits);
        return 1 << bits;
    endfunction

    // Byte-enable width for a given data width
    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/sram_ctrl_phy.sv
// Pin-level helpers: tristate driver for sram_d and the WE# flop.
// WE# is re-timed on the falling edge so address/data straddle it.
module sram_ctrl_phy #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              dout_en,
    input  logic [DATA_W-1:0] dout,
    input  logic              int_we_n,
    output logic [DATA_W-1:0] din,
    output logic              sram_we_n,
    inout  wire  [DATA_W-1:0] sram_d
);

    assign sram_d = dout_en ? dout : {DATA_W{1'bz}};
    assign din    = sram_d;

    // Half-cycle delayed WE#, forced high at once by reset
    always_ff @(negedge clock or posedge rst) begin
        if (rst) begin
            sram_we_n <= 1'b1;
        end else begin
            sram_we_n <= int_we_n;
        end
    end

endmodule

// File: rtl/sram_ctrl_burst.sv
// Parametrised async-SRAM controller with read bursts and wait states.
// Optional bus-turnaround cycle: define SRAM_CTRL_TURNAROUND_EN.
module sram_ctrl_burst
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 30,
    parameter int ID_W       = 2,
    parameter int BURST_BITS = 2,
    parameter int READ_WAIT  = 0,
    parameter int WRITE_WAIT = 0
) (
    input  logic                     clock,
    input  logic                     rst,
    output logic                     mem_waitrequest,
    input  logic [ID_W-1:0]          mem_id,
    input  logic [ADDR_W-1:0]        mem_address,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [DATA_W-1:0]        mem_writedata,
    input  logic [DATA_W/8-1:0]      mem_writedatamask,
    output logic [DATA_W-1:0]        mem_readdata,
    output logic [ID_W-1:0]          mem_readdataid,
    output logic [ADDR_W-1:0]        sram_a,
    inout  wire  [DATA_W-1:0]        sram_d,
    output logic                     sram_cs_n,
    output logic                     sram_oe_n,
    output logic                     sram_we_n,
    output logic [DATA_W/8-1:0]      sram_be_n
);

    localparam int BE_W      = be_width(DATA_W);
    localparam int BURST_LEN = burst_len(BURST_BITS);
    localparam int BCNT_W    = (BURST_BITS > 0) ? BURST_BITS : 1;

    state_t              state;
    state_t              state_nx;
    logic [3:0]          wait_cnt;
    logic [BCNT_W-1:0]   beat_cnt;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   dout;
    logic [DATA_W-1:0]   din;
    logic                dout_en;
    logic                int_we_n;

    logic                take;
    logic                to_turn;
    logic                launch;
    logic                launch_rd;
    logic [ID_W-1:0]     launch_id;
    logic [ADDR_W-1:0]   launch_addr;
    logic [DATA_W-1:0]   launch_data;
    logic [BE_W-1:0]     launch_mask;
    logic                beat_now;
    logic                beat_last;
    logic                write_done;

    assign mem_waitrequest = (state != IDLE);
    assign take       = (state == IDLE) && (mem_read || mem_write);
    assign beat_now   = (state == READ) && (wait_cnt == 4'd0);
    assign beat_last  = (beat_cnt == '0);
    assign write_done = (state == WRITE) && (wait_cnt == 4'd0);

`ifdef SRAM_CTRL_TURNAROUND_EN
    logic                last_wr;
    logic                req_wr_q;
    logic [ID_W-1:0]     req_id_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_data_q;
    logic [BE_W-1:0]     req_mask_q;

    // A read wins a tie, so the direction is write only without mem_read
    assign to_turn     = take && (mem_read ? last_wr : !last_wr);
    assign launch      = (take && !to_turn) || (state == TURN);
    assign launch_rd   = (state == TURN) ? !req_wr_q  : mem_read;
    assign launch_id   = (state == TURN) ? req_id_q   : mem_id;
    assign launch_addr = (state == TURN) ? req_addr_q : mem_address;
    assign launch_data = (state == TURN) ? req_data_q : mem_writedata;
    assign launch_mask = (state == TURN) ? req_mask_q : mem_writedatamask;

    // Hold the request across TURN and remember the last direction
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            last_wr    <= 1'b0;
            req_wr_q   <= 1'b0;
            req_id_q   <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_mask_q <= '0;
        end else begin
            if (take) begin
                req_wr_q   <= !mem_read;
                req_id_q   <= mem_id;
                req_addr_q <= mem_address;
                req_data_q <= mem_writedata;
                req_mask_q <= mem_writedatamask;
            end
            if (launch) begin
                last_wr <= !launch_rd;
            end
        end
    end
`else
    assign to_turn     = 1'b0;
    assign launch      = take;
    assign launch_rd   = mem_read;
    assign launch_id   = mem_id;
    assign launch_addr = mem_address;
    assign launch_data = mem_writedata;
    assign launch_mask = mem_writedatamask;
`endif

    // State register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (to_turn) begin
                    state_nx = TURN;
                end else if (launch) begin
                    state_nx = launch_rd ? READ : WRITE;
                end
            end
            TURN: begin
                state_nx = launch_rd ? READ : WRITE;
            end
            READ: begin
                if (beat_now && beat_last) begin
                    state_nx = IDLE;
                end
            end
            WRITE: begin
                if (write_done) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Strobes, address, write data and returned read beats
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sram_a         <= '0;
            sram_cs_n      <= 1'b1;
            sram_oe_n      <= 1'b1;
            sram_be_n      <= '1;
            dout_en        <= 1'b0;
            dout           <= '0;
            int_we_n       <= 1'b1;
            mem_readdata   <= '0;
            mem_readdataid <= '0;
            wait_cnt       <= 4'd0;
            beat_cnt       <= '0;
            id_q           <= '0;
        end else begin
            mem_readdataid <= '0;
            if (to_turn) begin
                sram_oe_n <= 1'b1;
                dout_en   <= 1'b0;
                int_we_n  <= 1'b1;
            end else if (launch) begin
                sram_a    <= launch_addr;
                sram_cs_n <= 1'b0;
                id_q      <= launch_id;
                if (launch_rd) begin
                    sram_oe_n <= 1'b0;
                    sram_be_n <= '0;
                    dout_en   <= 1'b0;
                    beat_cnt  <= BCNT_W'(BURST_LEN - 1);
                    wait_cnt  <= 4'(READ_WAIT);
                end else begin
                    dout      <= launch_data;
                    sram_be_n <= ~launch_mask;
                    dout_en   <= 1'b1;
                    sram_oe_n <= 1'b1;
                    int_we_n  <= 1'b0;
                    wait_cnt  <= 4'(WRITE_WAIT);
                end
            end else if (state == IDLE) begin
                sram_cs_n <= 1'b1;
                sram_oe_n <= 1'b1;
                int_we_n  <= 1'b1;
            end else if (state == READ) begin
                if (wait_cnt == 4'd0) begin
                    mem_readdata   <= din;
                    mem_readdataid <= id_q;
                    if (beat_last) begin
                        sram_oe_n <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt - 1'b1;
                        sram_a   <= sram_a + {{(ADDR_W-1){1'b0}}, 1'b1};
                        wait_cnt <= 4'(READ_WAIT);
                    end
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
            end else if (state == WRITE) begin
                if (wait_cnt == 4'd0) begin
                    int_we_n <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
            end
        end
    end

    sram_ctrl_phy #(
        .DATA_W (DATA_W)
    ) u_phy (
        .clock     (clock),
        .rst       (rst),
        .dout_en   (dout_en),
        .dout      (dout),
        .int_we_n  (int_we_n),
        .din       (din),
        .sram_we_n (sram_we_n),
        .sram_d    (sram_d)
    );

endmodule

// File: tb/tb_sram_ctrl_burst.sv
// Directed bench for sram_ctrl_burst with a behavioural SRAM model.
// Second instance exercises read/write wait states.
module tb_sram_ctrl_burst;

`ifdef SRAM_CTRL_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    typedef struct {
        bit               wr;
        logic [1:0]       id;
        logic [29:0]      addr;
        logic [31:0]      wdata;
        logic [3:0]       mask;
        logic [3:0]       ebe;
        logic [3:0][31:0] exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        rst;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit prev_wr = 1'b0;

    // main instance
    logic        mem_waitrequest;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;
    logic [29:0] sram_a;
    wire  [31:0] sram_d;
    logic        sram_cs_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    // wait-state instance
    logic        b_wr;
    logic [1:0]  b_id;
    logic [29:0] b_addr;
    logic        b_read;
    logic        b_write;
    logic [31:0] b_wdata;
    logic [3:0]  b_mask;
    logic [31:0] b_rdata;
    logic [1:0]  b_rid;
    logic [29:0] b_sram_a;
    wire  [31:0] b_sram_d;
    logic        b_cs_n;
    logic        b_oe_n;
    logic        b_we_n;
    logic [3:0]  b_be_n;

    logic [31:0] mem [0:1023];

    sram_ctrl_burst dut (
        .clock             (clock),
        .rst               (rst),
        .mem_waitrequest   (mem_waitrequest),
        .mem_id            (mem_id),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_writedatamask (mem_writedatamask),
        .mem_readdata      (mem_readdata),
        .mem_readdataid    (mem_readdataid),
        .sram_a            (sram_a),
        .sram_d            (sram_d),
        .sram_cs_n         (sram_cs_n),
        .sram_oe_n         (sram_oe_n),
        .sram_we_n         (sram_we_n),
        .sram_be_n         (sram_be_n)
    );

    sram_ctrl_burst #(
        .READ_WAIT  (2),
        .WRITE_WAIT (1)
    ) dut2 (
        .clock             (clock),
        .rst               (rst),
        .mem_waitrequest   (b_wr),
        .mem_id            (b_id),
        .mem_address       (b_addr),
        .mem_read          (b_read),
        .mem_write         (b_write),
        .mem_writedata     (b_wdata),
        .mem_writedatamask (b_mask),
        .mem_readdata      (b_rdata),
        .mem_readdataid    (b_rid),
        .sram_a            (b_sram_a),
        .sram_d            (b_sram_d),
        .sram_cs_n         (b_cs_n),
        .sram_oe_n         (b_oe_n),
        .sram_we_n         (b_we_n),
        .sram_be_n         (b_be_n)
    );

    // SRAM models: read while OE# and CS# low, write on WE# rising
    assign sram_d = (!sram_oe_n && !sram_cs_n) ? mem[sram_a[9:0]] : 'z;
    assign b_sram_d = (!b_oe_n && !b_cs_n) ?
                      (32'hC0DE0000 | 32'(b_sram_a[9:0])) : 'z;

    always @(posedge sram_we_n) begin
        if (!rst && !sram_cs_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) mem[sram_a[9:0]][b*8 +: 8] = sram_d[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t rv(input logic [1:0] id, input logic [29:0] a,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.wr = 1'b0; v.id = id; v.addr = a; v.wdata = '0; v.mask = '0;
        v.ebe = '0; v.exp = {e3, e2, e1, e0};
        return v;
    endfunction

    function automatic vec_t wv(input logic [29:0] a, input logic [31:0] d,
                                input logic [3:0] m, input logic [3:0] ebe);
        vec_t v;
        v.wr = 1'b1; v.id = '0; v.addr = a; v.wdata = d; v.mask = m;
        v.ebe = ebe; v.exp = '0;
        return v;
    endfunction

    // Issue a read (from idle, at posedge+1) and check all four beats
    task automatic do_read(input string nm, input logic [1:0] id,
                           input logic [29:0] a, input logic [3:0][31:0] e);
        int nb = 0;
        int busy = 0;
        int ebusy;
        ebusy = 4 + ((TURN_EN && prev_wr) ? 1 : 0);
        mem_id = id; mem_address = a; mem_read = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock); #1;
            mem_read = 1'b0;
            if (mem_readdataid != 2'd0) begin
                chk($sformatf("%s id%0d", nm, nb), 64'(mem_readdataid), 64'(id));
                if (nb < 4) chk($sformatf("%s beat%0d", nm, nb), 64'(mem_readdata), 64'(e[nb]));
                nb++;
            end
            if (mem_waitrequest) busy++;
            if (nb >= 4 && !mem_waitrequest) break;
        end
        chk({nm, " beats"}, 64'(nb), 64'd4);
        chk({nm, " busy"}, 64'(busy), 64'(ebusy));
        prev_wr = 1'b0;
    endtask

    // Write; 'held' means mem_write is already raised by the caller
    task automatic do_write(input string nm, input logic [29:0] a, input logic [31:0] d,
                            input logic [3:0] m, input logic [3:0] ebe, input bit held);
        int gap = 0;
        int low = 0;
        bit seen = 1'b0;
        int egap;
        egap = (TURN_EN && !prev_wr) ? 1 : 0;
        if (!held) begin
            mem_address = a; mem_writedata = d; mem_writedatamask = m;
            mem_write = 1'b1;
        end
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clock); #1;
            if (mem_waitrequest) mem_write = 1'b0;
            if (mem_waitrequest && dut.dout_en) seen = 1'b1;
            else if (mem_waitrequest && sram_oe_n) gap++;
        end
        chk({nm, " started"}, 64'(seen), 64'd1);
        chk({nm, " turn gap"}, 64'(gap), 64'(egap));
        chk({nm, " be_n"}, 64'(sram_be_n), 64'(ebe));
        chk({nm, " we_n offset"}, 64'(sram_we_n), 64'd1);
        for (int k = 0; k < 40; k++) begin
            if (!sram_we_n) low++;
            else if (low > 0) break;
            @(posedge clock); #1;
        end
        chk({nm, " we_n low"}, 64'(low), 64'd1);
        chk({nm, " idle"}, 64'(mem_waitrequest), 64'd0);
        prev_wr = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = rv(2'd1, 30'h100, 32'hC0DE0100, 32'hC0DE0101, 32'hC0DE0102, 32'hC0DE0103);
        vecs[1] = wv(30'h20, 32'hDEADBEEF, 4'b0101, 4'b1010);
        vecs[2] = rv(2'd2, 30'h20, 32'hC0AD00EF, 32'hC0DE0021, 32'hC0DE0022, 32'hC0DE0023);
        vecs[3] = rv(2'd3, 30'h3FFFFFFF, 32'hC0DE03FF, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002);
        vecs[4] = wv(30'h3FF, 32'h12345678, 4'b1111, 4'b0000);
        vecs[5] = rv(2'd1, 30'h3FE, 32'hC0DE03FE, 32'h12345678, 32'hC0DE0000, 32'hC0DE0001);
        vecs[6] = wv(30'h101, 32'hA5A5A5A5, 4'b1000, 4'b0111);
        vecs[7] = rv(2'd2, 30'h100, 32'hC0DE0100, 32'hA5DE0101, 32'hC0DE0102, 32'hC0DE0103);

        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);

        rst = 1'b1;
        mem_id = '0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_writedata = '0; mem_writedatamask = '0;
        b_id = '0; b_addr = '0; b_read = 1'b0; b_write = 1'b0;
        b_wdata = '0; b_mask = '0;

        #12;
        chk("rst waitreq", 64'(mem_waitrequest), 64'd0);
        chk("rst rdata", 64'(mem_readdata), 64'd0);
        chk("rst rid", 64'(mem_readdataid), 64'd0);
        chk("rst addr", 64'(sram_a), 64'd0);
        chk("rst strobes", 64'({sram_cs_n, sram_oe_n, sram_we_n}), 64'h7);
        chk("rst be_n", 64'(sram_be_n), 64'hF);
        chk("rst dout_en", 64'(dut.dout_en), 64'd0);
        #1 rst = 1'b0;
        @(posedge clock); #1;

        // table: reads, writes, read-backs, address wrap
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr)
                do_write($sformatf("v%0d", i), vecs[i].addr, vecs[i].wdata,
                         vecs[i].mask, vecs[i].ebe, 1'b0);
            else
                do_read($sformatf("v%0d", i), vecs[i].id, vecs[i].addr, vecs[i].exp);
        end

        // read and write together: read first, write after the burst
        mem_address = 30'h40; mem_writedata = 32'h11223344;
        mem_writedatamask = 4'b1111; mem_write = 1'b1;
        do_read("tie rd", 2'd3, 30'h40,
                {32'hC0DE0043, 32'hC0DE0042, 32'hC0DE0041, 32'hC0DE0040});
        chk("tie wr pending", 64'(mem_write), 64'd1);
        do_write("tie wr", 30'h40, 32'h11223344, 4'b1111, 4'b0000, 1'b1);
        do_read("tie back", 2'd1, 30'h40,
                {32'hC0DE0043, 32'hC0DE0042, 32'hC0DE0041, 32'h11223344});

        // wait-state instance: beat every 3 cycles, 12 busy cycles
        begin
            int busy = 0;
            int low = 0;
            bit seen = 1'b0;
            b_id = 2'd3; b_addr = 30'h10; b_read = 1'b1;
            for (int c = 0; c <= 13; c++) begin
                @(posedge clock); #1;
                b_read = 1'b0;
                if (b_wr) busy++;
                if (c > 0 && c % 3 == 0 && c <= 12) begin
                    chk($sformatf("rw2 id c%0d", c), 64'(b_rid), 64'd3);
                    chk($sformatf("rw2 data c%0d", c), 64'(b_rdata),
                        64'(32'hC0DE0010 + 32'(c / 3 - 1)));
                end else begin
                    chk($sformatf("rw2 gap c%0d", c), 64'(b_rid), 64'd0);
                end
            end
            chk("rw2 busy", 64'(busy), 64'd12);

            b_addr = 30'h11; b_wdata = 32'h55AA55AA; b_mask = 4'b0011;
            b_write = 1'b1;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(posedge clock); #1;
                if (b_wr) b_write = 1'b0;
                if (b_wr && dut2.dout_en) seen = 1'b1;
            end
            chk("ww1 started", 64'(seen), 64'd1);
            chk("ww1 be_n", 64'(b_be_n), 64'hC);
            for (int k = 0; k < 40; k++) begin
                if (!b_we_n) low++;
                else if (low > 0) break;
                @(posedge clock); #1;
            end
            chk("ww1 we_n low", 64'(low), 64'd2);
        end

        // reset during the second beat of a burst
        mem_id = 2'd2; mem_address = 30'h180; mem_read = 1'b1;
        @(posedge clock); #1;
        mem_read = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("abort beat1", 64'(mem_readdata), 64'h00000000C0DE0181);
        #2 rst = 1'b1;
        #1;
        chk("abort strobes", 64'({sram_cs_n, sram_oe_n, sram_we_n}), 64'h7);
        chk("abort be_n", 64'(sram_be_n), 64'hF);
        chk("abort rid", 64'(mem_readdataid), 64'd0);
        chk("abort waitreq", 64'(mem_waitrequest), 64'd0);
        @(posedge clock); #3 rst = 1'b0;
        @(posedge clock); #1;
        prev_wr = 1'b0;
        do_read("post rst", 2'd1, 30'h200,
                {32'hC0DE0203, 32'hC0DE0202, 32'hC0DE0201, 32'hC0DE0200});

        // reset while WE# is low releases it immediately
        begin
            bit seen = 1'b0;
            mem_address = 30'h60; mem_writedata = 32'hFFFFFFFF;
            mem_writedatamask = 4'hF; mem_write = 1'b1;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(posedge clock); #1;
                if (mem_waitrequest) mem_write = 1'b0;
                if (mem_waitrequest && dut.dout_en) seen = 1'b1;
            end
            chk("wabort started", 64'(seen), 64'd1);
            #5;
            chk("wabort we_n low", 64'(sram_we_n), 64'd0);
            rst = 1'b1;
            #1;
            chk("wabort we_n", 64'(sram_we_n), 64'd1);
            @(posedge clock); #3 rst = 1'b0;
            @(posedge clock); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
